// File: rtl/io_avalon_poller.sv
// Avalon-MM initiator for the IO input-controller slave. It serialises local commands
// with periodic and irq-triggered polls, and returns one response per transaction.
module io_avalon_poller #(
  parameter int         DATA_WIDTH     = 64,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         POLL_PERIOD    = 50000,
  parameter logic [3:0] POLL_OPCODE    = 4'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_opcode,
  input  logic [DATA_WIDTH-5:0] cmd_payload,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_timeout,
  output logic                  rsp_polled,
  output logic                  av_we,
  output logic [DATA_WIDTH-1:0] av_writedata,
  input  logic [DATA_WIDTH-1:0] av_readdata,
  input  logic                  av_waitrequest,
  input  logic                  av_irq,
  output logic                  busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'((POLL_PERIOD > 0) ? POLL_PERIOD - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  is_poll_q, is_poll_d;
  logic                  to_flag_q, to_flag_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic [PW-1:0]         poll_cnt_q;
  logic                  pending_q;
  logic                  irq_q;
  logic                  poll_take;
  logic                  poll_wrap;
  logic                  irq_rise;

  assign poll_wrap = (POLL_PERIOD > 0) && (poll_cnt_q == POLL_LAST);
  assign irq_rise  = av_irq & ~irq_q;

  // NOTE: every signal written below gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    wdata_d     = wdata_q;
    rsp_data_d  = rsp_data_q;
    is_poll_d   = is_poll_q;
    to_flag_d   = to_flag_q;
    to_cnt_d    = to_cnt_q;
    poll_take   = 1'b0;
    cmd_ready   = 1'b0;
    av_we       = 1'b0;
    rsp_valid   = 1'b0;
    rsp_timeout = 1'b0;
    rsp_polled  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A pending poll blocks commands for this cycle and is issued first.
        cmd_ready = ~pending_q & ~rst;
        to_cnt_d  = '0;
        to_flag_d = 1'b0;
        if (pending_q) begin
          wdata_d   = DATA_WIDTH'(POLL_OPCODE);
          is_poll_d = 1'b1;
          poll_take = 1'b1;
          state_d   = ISSUE;
        end else if (cmd_valid) begin
          wdata_d   = {cmd_payload, cmd_opcode};
          is_poll_d = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        av_we    = 1'b1;
        to_cnt_d = to_cnt_q + 1'b1;
        if (!av_waitrequest) begin
          rsp_data_d = av_readdata;
          state_d    = RESP;
        end else if (to_cnt_q == TO_LAST) begin
          rsp_data_d = '0;
          to_flag_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        rsp_valid   = 1'b1;
        rsp_timeout = to_flag_q;
        rsp_polled  = is_poll_q;
        to_cnt_d    = '0;
        to_flag_d   = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      is_poll_q  <= 1'b0;
      to_flag_q  <= 1'b0;
      to_cnt_q   <= '0;
      poll_cnt_q <= '0;
      pending_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      is_poll_q  <= is_poll_d;
      to_flag_q  <= to_flag_d;
      to_cnt_q   <= to_cnt_d;
      if (POLL_PERIOD > 0) poll_cnt_q <= poll_wrap ? '0 : poll_cnt_q + 1'b1;
      // Triggers arriving while a poll is pending merge into that one poll.
      pending_q  <= (pending_q & ~poll_take) | poll_wrap | irq_rise;
      irq_q      <= av_irq;
    end
  end

  assign av_writedata = wdata_q;
  assign rsp_data     = rsp_data_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_io_avalon_poller.sv
// Self-checking bench for io_avalon_poller: randomized commands and a slave model with
// a response scoreboard, plus a second instance that only exercises periodic polling.
`timescale 1ns/1ps
module tb_io_avalon_poller;

  localparam int          TO     = 8;
  localparam int          PP     = 20;
  localparam logic [63:0] POLL_RD = 64'h0123_4567_89AB_CDEF;

  typedef struct {
    logic [63:0] wdata;
    logic [63:0] data;
    bit          timeout;
    bit          polled;
    int          we_len;
    int          accept;
  } exp_t;

  typedef struct {
    int          stall;
    logic [63:0] data;
  } plan_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: no periodic polls, short timeout.
  logic        rst, cmd_valid, cmd_ready, rsp_valid, rsp_timeout, rsp_polled;
  logic        av_we, av_waitrequest, av_irq, busy;
  logic [3:0]  cmd_opcode;
  logic [59:0] cmd_payload;
  logic [63:0] rsp_data, av_writedata, av_readdata;

  io_avalon_poller #(.DATA_WIDTH(64), .TIMEOUT_CYCLES(TO), .POLL_PERIOD(0), .POLL_OPCODE(4'h1)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_payload(cmd_payload), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .rsp_polled(rsp_polled),
    .av_we(av_we), .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest), .av_irq(av_irq), .busy(busy)
  );

  // Poll-only instance with a 20-cycle period.
  logic        p_rst, p_cmd_valid, p_cmd_ready, p_rsp_valid, p_rsp_timeout, p_rsp_polled;
  logic        p_we, p_waitrequest, p_irq, p_busy;
  logic [3:0]  p_opcode;
  logic [59:0] p_payload;
  logic [63:0] p_rsp_data, p_wdata, p_readdata;

  io_avalon_poller #(.DATA_WIDTH(64), .TIMEOUT_CYCLES(TO), .POLL_PERIOD(PP), .POLL_OPCODE(4'h1)) u_poll (
    .clk(clk), .rst(p_rst), .cmd_valid(p_cmd_valid), .cmd_ready(p_cmd_ready),
    .cmd_opcode(p_opcode), .cmd_payload(p_payload), .rsp_valid(p_rsp_valid),
    .rsp_data(p_rsp_data), .rsp_timeout(p_rsp_timeout), .rsp_polled(p_rsp_polled),
    .av_we(p_we), .av_writedata(p_wdata), .av_readdata(p_readdata),
    .av_waitrequest(p_waitrequest), .av_irq(p_irq), .busy(p_busy)
  );

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    poll_cnt = 0;
  bit    mon_abort;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected response derived from how long the slave stalls.
  function automatic exp_t model(input logic [63:0] wd, input int stall, input logic [63:0] data,
                                 input bit polled, input int acc);
    exp_t e;
    e.wdata  = wd;
    e.polled = polled;
    e.accept = acc;
    if (stall >= TO) begin
      e.data = '0; e.timeout = 1'b1; e.we_len = TO;
    end else begin
      e.data = data; e.timeout = 1'b0; e.we_len = stall + 1;
    end
    return e;
  endfunction

  // Call at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input logic [3:0] op, input logic [59:0] pl, input int stall,
                          input logic [63:0] data, output int acc);
    int n;
    n = 0;
    acc = -1;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_payload = pl;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accepted", cmd_ready, 1);
    if (cmd_ready) begin
      acc = cyc;
      plan_q.push_back('{stall, data});
      exp_q.push_back(model({pl, op}, stall, data, 1'b0, cyc));
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_opcode = 4'($urandom); cmd_payload = 60'({$urandom, $urandom});
  endtask

  task automatic push_poll(input int stall, input logic [63:0] data);
    plan_q.push_back('{stall, data});
    exp_q.push_back(model(64'h1, stall, data, 1'b1, -1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", (exp_q.size() == 0) && !busy, 1);
    @(negedge clk);
  endtask

  // Slave model: each transaction follows the next plan (stall count, then data).
  initial begin
    plan_t cur;
    int    scnt;
    scnt = 0;
    cur.stall = 1000; cur.data = '0;
    av_waitrequest = 1'b1;
    av_readdata = '0;
    forever begin
      @(negedge clk);
      if (av_we) begin
        if (scnt == 0) begin
          if (plan_q.size() > 0) cur = plan_q.pop_front();
          else begin cur.stall = 1000; cur.data = '0; end
        end
        if (scnt < cur.stall) begin
          av_waitrequest = 1'b1;
          av_readdata = {$urandom, $urandom};
        end else begin
          av_waitrequest = 1'b0;
          av_readdata = cur.data;
        end
        scnt++;
      end else begin
        scnt = 0;
        av_waitrequest = 1'($urandom_range(0, 1));
        av_readdata = {$urandom, $urandom};
      end
    end
  end

  // Monitor: measures each av_we burst and scores every response strobe.
  initial begin
    int          we_len, we_start;
    logic [63:0] we_data;
    bit          wd_ok, busy_ok;
    exp_t        e;
    we_len = 0; we_start = 0; we_data = '0; wd_ok = 1'b1; busy_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_abort) begin
        we_len = 0;
        continue;
      end
      if (av_we) begin
        if (we_len == 0) begin
          we_start = cyc; we_data = av_writedata; wd_ok = 1'b1; busy_ok = 1'b1;
        end else if (av_writedata !== we_data) wd_ok = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        we_len++;
      end
      if (rsp_valid) begin
        check("rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("writedata", we_data, e.wdata);
          check("we_cycles", we_len, e.we_len);
          check("writedata_stable", wd_ok, 1);
          check("busy_in_txn", busy_ok && busy, 1);
          check("rsp_data", rsp_data, e.data);
          check("rsp_timeout", rsp_timeout, e.timeout);
          check("rsp_polled", rsp_polled, e.polled);
          check("rsp_after_we", cyc, we_start + we_len);
          if (e.accept >= 0) check("issue_latency", we_start, e.accept + 1);
        end
        we_len = 0;
      end
    end
  end

  // Poll-instance stimulus and monitor.
  initial begin
    int last_rise;
    bit have_rise, prev_we;
    p_cmd_valid = 1'b0; p_opcode = '0; p_payload = '0;
    p_readdata = POLL_RD; p_waitrequest = 1'b0; p_irq = 1'b0;
    last_rise = 0; have_rise = 1'b0; prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (p_we && !prev_we && poll_cnt < 8) begin
        if (have_rise) check("poll_interval", cyc - last_rise, PP);
        check("poll_writedata", p_wdata, 64'h1);
        last_rise = cyc;
        have_rise = 1'b1;
      end
      if (p_rsp_valid && poll_cnt < 8) begin
        check("poll_rsp_polled", p_rsp_polled, 1);
        check("poll_rsp_data", p_rsp_data, POLL_RD);
        check("poll_rsp_timeout", p_rsp_timeout, 0);
        poll_cnt++;
      end
      prev_we = p_we;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, c0, quiet_bad;
    rst = 1'b1; p_rst = 1'b1; mon_abort = 1'b0;
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_payload = '0; av_irq = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_av_we", av_we, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_writedata", av_writedata, 0);
    check("reset_rsp_data", rsp_data, 0);
    rst = 1'b0; p_rst = 1'b0;
    @(negedge clk);

    // Basic command with immediate completion and latency checks.
    send_cmd(4'h3, 60'h5, 0, 64'hA5, acc);
    check("basic_we_n1", av_we, 1);
    check("basic_ready_n1", cmd_ready, 0);
    @(negedge clk);
    check("basic_rsp_n2", rsp_valid, 1);
    @(negedge clk);
    check("basic_ready_n3", cmd_ready, 1);
    drain();

    // Five stall cycles, then a stuck slave that times out.
    send_cmd(4'hC, 60'h0ABC_DEF0_1234_567, 5, 64'hFEED_FACE_CAFE_BEEF, acc);
    drain();
    send_cmd(4'h7, 60'h123, 40, 64'h1111, acc);
    drain();
    check("ready_after_timeout", cmd_ready, 1);

    // Two irq rises during a command's ISSUE collapse into one poll.
    send_cmd(4'h9, 60'h77, 4, 64'h2222_3333, acc);
    push_poll(2, 64'h4444_5555);
    av_irq = 1'b1; @(negedge clk);
    av_irq = 1'b0; @(negedge clk);
    av_irq = 1'b1; @(negedge clk);
    av_irq = 1'b0;
    while (cyc < acc + 7) @(negedge clk);
    check("irq_idle_ready_low", cmd_ready, 0);
    check("irq_idle_not_busy", busy, 0);
    @(negedge clk);
    check("irq_poll_issued", av_we, 1);
    drain();
    repeat (10) @(negedge clk);

    // Command and irq rise in the same idle cycle: command first, poll next.
    c0 = cyc;
    av_irq = 1'b1;
    send_cmd(4'h5, 60'h9, $urandom_range(0, 3), {$urandom, $urandom}, acc);
    check("collision_cmd_first", acc, c0);
    push_poll($urandom_range(0, 3), {$urandom, $urandom});
    av_irq = 1'b0;
    drain();

    // Randomized commands with occasional idle-time irq polls.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 4) == 0) begin
        drain();
        push_poll($urandom_range(0, 10), {$urandom, $urandom});
        av_irq = 1'b1; @(negedge clk);
        av_irq = 1'b0;
      end
      send_cmd(4'($urandom_range(0, 15)), 60'({$urandom, $urandom}), $urandom_range(0, 11),
               {$urandom, $urandom}, acc);
    end
    drain();

    // Reset while av_we is high with an irq poll pending.
    send_cmd(4'hA, 60'h55, 50, 64'h6666, acc);
    mon_abort = 1'b1;
    av_irq = 1'b1;
    @(negedge clk);
    check("pre_reset_we", av_we, 1);
    rst = 1'b1;
    av_irq = 1'b0;
    exp_q.delete();
    plan_q.delete();
    @(negedge clk);
    check("midreset_we_low", av_we, 0);
    check("midreset_rsp_valid", rsp_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready", cmd_ready, 1);
    quiet_bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (av_we || rsp_valid) quiet_bad++;
    end
    check("post_reset_quiet", quiet_bad, 0);
    mon_abort = 1'b0;
    @(negedge clk);
    send_cmd(4'h2, 60'h42, 1, 64'h8888_9999, acc);
    drain();

    check("poll_count", poll_cnt >= 3, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
